t_logic_stream: RTL and testbench

//  Parametrised, streaming successor of the 5-input/2-output "t" logic benchmark.
//  - Evaluates the t function bitwise over WIDTH-bit channels:
//      po0 = (pi1 & ~(pi2 & pi3)) | (pi0 & pi2)
//      po1 = ~(pi2 & pi3) & (pi1 | pi4)
//  - Adds a per-word mode select.
//  - Buffers results in a DEPTH-entry FIFO behind valid/ready handshakes on both sides.
//  - Counts delivered words.
//  - Used as a sequential benchmark and as a bitwise mapping block in larger designs.

---
 rtl/t_logic_stream_if.sv | 30 +++
 rtl/t_logic_stream.sv | 90 +++++++++
 tb/tb_t_logic_stream.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/t_logic_stream_if.sv
// Handshake bundle for t_logic_stream.
// The source/consumer side uses master; the block uses slave.
interface t_logic_stream_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pi0;
    logic [WIDTH-1:0] pi1;
    logic [WIDTH-1:0] pi2;
    logic [WIDTH-1:0] pi3;
    logic [WIDTH-1:0] pi4;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] po0;
    logic [WIDTH-1:0] po1;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output in_valid, mode, pi0, pi1, pi2, pi3, pi4, out_ready,
        input  in_ready, out_valid, po0, po1, word_cnt
    );

    modport slave (
        input  in_valid, mode, pi0, pi1, pi2, pi3, pi4, out_ready,
        output in_ready, out_valid, po0, po1, word_cnt
    );
endinterface

// File: rtl/t_logic_stream.sv
// Streaming bitwise "t" logic function with per-word mode,
// a DEPTH-entry result FIFO and a wrapping delivered-word counter.
module t_logic_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    t_logic_stream_if.slave  s
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef logic [2*WIDTH-1:0] ent_t;

    ent_t             mem_q [DEPTH];
    ent_t             mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] r0, r1, w0, w1;
    logic             acc, pop, empty;

    always_comb begin
        r0 = (s.pi1 & ~(s.pi2 & s.pi3)) | (s.pi0 & s.pi2);
        r1 = ~(s.pi2 & s.pi3) & (s.pi1 | s.pi4);
        w0 = r0;
        w1 = r1;
        unique case (s.mode)
            2'b00: begin w0 = r0;  w1 = r1;  end
            2'b01: begin w0 = ~r0; w1 = ~r1; end
            2'b10: begin w0 = r1;  w1 = r0;  end
            2'b11: begin w0 = s.pi0; w1 = s.pi1; end
        endcase
    end

    always_comb begin
        empty = (occ_q == '0);
        acc   = s.in_valid & rdy_q;
        pop   = s.out_ready & ~empty;

        mem_d = mem_q;
        if (acc) begin
            mem_d[wr_q] = {w0, w1};
        end

        wr_d  = wr_q + PW'(acc);
        rd_d  = rd_q + PW'(pop);
        cnt_d = cnt_q + CNT_W'(pop);

        occ_d = occ_q;
        if (acc && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (!acc && pop) begin
            occ_d = occ_q - OW'(1);
        end

        // Ready is registered so a same-cycle pop cannot reopen a full FIFO
        rdy_d = (occ_d != OW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    assign s.in_ready   = rdy_q;
    assign s.out_valid  = ~empty;
    assign {s.po0, s.po1} = empty ? '0 : mem_q[rd_q];
    assign s.word_cnt   = cnt_q;
endmodule

// File: tb/tb_t_logic_stream.sv
// Randomised scoreboard bench for t_logic_stream
// (WIDTH=4, DEPTH=4, CNT_W=3).
module tb_t_logic_stream;
    localparam int W = 4;
    localparam int D = 4;
    localparam int CW = 3;

    localparam logic [3:0] V0 = 4'b0001;
    localparam logic [3:0] V1 = 4'b0010;
    localparam logic [3:0] V2 = 4'b0101;
    localparam logic [3:0] V3 = 4'b0100;
    localparam logic [3:0] V4 = 4'b1000;

    logic clk;
    logic rst;
    logic armed;

    t_logic_stream_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    t_logic_stream #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    int n_chk;
    int n_fail;
    logic [7:0] sb [$];
    int occ;
    logic [CW-1:0] ecnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) armed <= 1'b0;
        else     armed <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: per-bit truth of the t function, then the mode mapping
    function automatic logic [7:0] ref_t(input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] a2, input logic [3:0] a3,
                                         input logic [3:0] a4, input logic [1:0] m);
        logic [3:0] r0, r1;
        for (int b = 0; b < 4; b++) begin
            r0[b] = (a1[b] && !(a2[b] && a3[b])) || (a0[b] && a2[b]);
            r1[b] = !(a2[b] && a3[b]) && (a1[b] || a4[b]);
        end
        case (m)
            2'd0:    return {r0, r1};
            2'd1:    return {~r0, ~r1};
            2'd2:    return {r1, r0};
            default: return {a0, a1};
        endcase
    endfunction

    // Monitor: checks handshake state against a model occupancy and pops the scoreboard
    initial begin
        logic [7:0] e;
        bit a, p;
        occ  = 0;
        ecnt = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                occ  = 0;
                ecnt = '0;
            end else begin
                chk("out_valid", 32'(bus.out_valid), 32'(occ != 0));
                chk("in_ready", 32'(bus.in_ready), 32'(armed && occ != D));
                chk("word_cnt", 32'(bus.word_cnt), 32'(ecnt));
                if (!bus.out_valid) begin
                    chk("idle_po0", 32'(bus.po0), 32'd0);
                    chk("idle_po1", 32'(bus.po1), 32'd0);
                end
                a = bus.in_valid && bus.in_ready;
                p = bus.out_valid && bus.out_ready;
                if (p) begin
                    if (sb.size() == 0) begin
                        chk("pop_empty_sb", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("head_po0", 32'(bus.po0), 32'(e[7:4]));
                        chk("head_po1", 32'(bus.po1), 32'(e[3:0]));
                    end
                    ecnt = ecnt + 1'b1;
                end
                occ = occ + int'(a) - int'(p);
            end
        end
    end

    task automatic step(output bit acc);
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            sb.push_back(ref_t(bus.pi0, bus.pi1, bus.pi2, bus.pi3, bus.pi4, bus.mode));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] a0, input logic [3:0] a1,
                          input logic [3:0] a2, input logic [3:0] a3,
                          input logic [3:0] a4, input logic [1:0] m);
        bus.pi0 = a0; bus.pi1 = a1; bus.pi2 = a2;
        bus.pi3 = a3; bus.pi4 = a4; bus.mode = m;
    endtask

    task automatic send(input logic [3:0] a0, input logic [3:0] a1,
                        input logic [3:0] a2, input logic [3:0] a3,
                        input logic [3:0] a4, input logic [1:0] m);
        bit acc;
        int n;
        set_in(a0, a1, a2, a3, a4, m);
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            step(acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'd1, 32'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [1:0] m);
        send(4'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom), m);
    endtask

    task automatic drain();
        bit acc;
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            step(acc);
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
        bus.out_ready = 1'b0;
    endtask

    task automatic directed(input logic [1:0] m, input logic [3:0] e0,
                            input logic [3:0] e1);
        bit acc;
        bus.out_ready = 1'b0;
        send(V0, V1, V2, V3, V4, m);
        @(negedge clk);
        chk("dir_valid", 32'(bus.out_valid), 32'd1);
        chk("dir_po0", 32'(bus.po0), 32'(e0));
        chk("dir_po1", 32'(bus.po1), 32'(e1));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        step(acc);
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_po0", 32'(bus.po0), 32'd0);
        chk("rst_po1", 32'(bus.po1), 32'd0);
        chk("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(bus.in_ready), 32'd1);

        directed(2'b00, 4'b0011, 4'b1010);
        chk("cnt_after_first_pop", 32'(bus.word_cnt), 32'd1);
        directed(2'b01, 4'b1100, 4'b0101);
        directed(2'b10, 4'b1010, 4'b0011);
        directed(2'b11, 4'b0001, 4'b0010);

        // Fill, hold a fifth word, then a single-cycle pop
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_rand(2'($urandom));
        chk("full_ready_low", 32'(bus.in_ready), 32'd0);
        set_in(V0, V1, V2, V3, V4, 2'b00);
        bus.in_valid = 1'b1;
        repeat (3) step(acc);
        chk("held_ready_low", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step(acc);
        chk("full_pop_no_accept", 32'(acc), 32'd0);
        bus.out_ready = 1'b0;
        chk("ready_after_pop", 32'(bus.in_ready), 32'd1);
        step(acc);
        chk("held_word_accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        drain();

        // Counter wrap: 9 pops on a 3-bit counter
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send_rand(2'($urandom));
        drain();
        chk("cnt_wrap", 32'(bus.word_cnt), 32'd1);

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            if (!bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                set_in(4'($urandom), 4'($urandom), 4'($urandom),
                       4'($urandom), 4'($urandom), 2'($urandom));
            end
            bus.out_ready = 1'($urandom);
            step(acc);
            if (acc) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        drain();

        // Reset mid-stream with words queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(2'($urandom));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_po0", 32'(bus.po0), 32'd0);
        chk("midrst_po1", 32'(bus.po1), 32'd0);
        chk("midrst_word_cnt", 32'(bus.word_cnt), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_empty", 32'(bus.out_valid), 32'd0);
        send(V0, V1, V2, V3, V4, 2'b00);
        drain();
        chk("post_rst_cnt", 32'(bus.word_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
